// File: rtl/upsampling.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | upsampling                                                                 |
// | Streaming nearest-neighbour 2x upsampler with a one-row line buffer.       |
// | Define UPSAMPLING_VDUP_EN to also duplicate rows vertically.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module upsampling #(
  parameter int WIDTH   = 8,
  parameter int IN_COLS = 2,
  parameter int IN_ROWS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam logic [CW-1:0] C_COL_LAST = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IN_ROWS - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_EMIT0 = 2'd1,
    S_EMIT1 = 2'd2
  } state_t;

`ifdef UPSAMPLING_VDUP_EN
  localparam state_t C_LAST_EMIT = S_EMIT1;
`else
  localparam state_t C_LAST_EMIT = S_EMIT0;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             h_q, h_d;
  logic [WIDTH-1:0] line_q [IN_COLS];
  logic [WIDTH-1:0] line_d [IN_COLS];

  logic             w_resync;
  logic [CW-1:0]    w_wr_col;
  logic             w_row_end;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    h_d     = h_q;
    line_d  = line_q;

    // A frame start seen anywhere but (0,0) restarts the frame at this pixel.
    w_resync  = in_sof && ((row_q != '0) || (col_q != '0));
    w_wr_col  = w_resync ? '0 : col_q;
    w_row_end = (col_q == C_COL_LAST) && h_q;

    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          line_d[w_wr_col] = in_data;
          if (w_resync) begin
            row_d = '0;
          end
          if (w_wr_col == C_COL_LAST) begin
            col_d   = '0;
            h_d     = 1'b0;
            state_d = S_EMIT0;
          end else begin
            col_d = w_wr_col + 1'b1;
          end
        end
      end
      S_EMIT0, S_EMIT1: begin
        if (out_ready) begin
          h_d = ~h_q;
          if (h_q) begin
            col_d = col_q + 1'b1;
          end
          if (w_row_end) begin
            col_d = '0;
            if (state_q == C_LAST_EMIT) begin
              state_d = S_FILL;
              row_d   = (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
              state_d = S_EMIT1;
            end
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      col_q   <= '0;
      row_q   <= '0;
      h_q     <= 1'b0;
      for (int i = 0; i < IN_COLS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      h_q     <= h_d;
      line_q  <= line_d;
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign in_ready  = rst_n && (state_q == S_FILL);
  assign out_valid = rst_n && (state_q != S_FILL);
  assign out_data  = out_valid ? line_q[col_q] : '0;
  assign out_sof   = out_valid && (row_q == '0) && (col_q == '0) && !h_q
                     && (state_q == S_EMIT0);
  assign out_eol   = out_valid && w_row_end;
  assign out_eof   = out_eol && (row_q == C_ROW_LAST) && (state_q == C_LAST_EMIT);

endmodule
`default_nettype wire

// File: tb/tb_upsampling.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_upsampling                                                              |
// | Scoreboard bench for upsampling; honours UPSAMPLING_VDUP_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_upsampling;

  localparam int WIDTH   = 8;
  localparam int IN_COLS = 2;
  localparam int IN_ROWS = 2;
`ifdef UPSAMPLING_VDUP_EN
  localparam int VPASS = 2;
`else
  localparam int VPASS = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b1;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;

  upsampling #(
    .WIDTH   (WIDTH),
    .IN_COLS (IN_COLS),
    .IN_ROWS (IN_ROWS)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             sof;
    logic             eol;
    logic             eof;
    logic             pass_end;
  } beat_t;

  beat_t            sb[$];
  int               total = 0;
  int               bad = 0;
  int               n_beats = 0;
  bit               bp = 1'b0;
  logic [WIDTH-1:0] frame_px [IN_ROWS][IN_COLS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_frame(input int base);
    for (int r = 0; r < IN_ROWS; r++)
      for (int c = 0; c < IN_COLS; c++)
        frame_px[r][c] = WIDTH'(base + r * IN_COLS + c);
  endtask

  // Expected output of one buffered input row, including vertical copies.
  task automatic push_row(input int r);
    beat_t e;
    for (int v = 0; v < VPASS; v++)
      for (int c = 0; c < IN_COLS; c++)
        for (int h = 0; h < 2; h++) begin
          e.d        = frame_px[r][c];
          e.sof      = (r == 0) && (v == 0) && (c == 0) && (h == 0);
          e.eol      = (c == IN_COLS - 1) && (h == 1);
          e.eof      = e.eol && (r == IN_ROWS - 1) && (v == VPASS - 1);
          e.pass_end = e.eol && (v == VPASS - 1);
          sb.push_back(e);
        end
  endtask

  task automatic push_frame();
    for (int r = 0; r < IN_ROWS; r++) push_row(r);
  endtask

  task automatic send_px(input logic [WIDTH-1:0] d, input logic sof);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_row(input int r);
    for (int c = 0; c < IN_COLS; c++) send_px(frame_px[r][c], (r == 0) && (c == 0));
    @(negedge clk);
    check_eq("latency_valid", out_valid, 1);
    check_eq("latency_data", out_data, frame_px[r][0]);
  endtask

  task automatic send_frame();
    for (int r = 0; r < IN_ROWS; r++) send_row(r);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: steady high, or the repeating 1,0,0,1 pattern.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        out_ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    bit                 prev_stall = 1'b0;
    bit                 want_rdy = 1'b0;
    logic [WIDTH+2:0]   prev_out = '0;
    beat_t              e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        want_rdy   = 1'b0;
      end else begin
        if (want_rdy) begin
          check_eq("no_dead_cycle", in_ready, 1);
          want_rdy = 1'b0;
        end
        if (prev_stall) begin
          check_eq("stall_valid", out_valid, 1);
          check_eq("stall_hold", {out_data, out_sof, out_eol, out_eof}, prev_out);
        end
        if (out_valid) check_eq("in_ready_emit", in_ready, 0);
        else check_eq("idle_zero", {out_data, out_sof, out_eol, out_eof}, 0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("sb_nonempty", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check_eq("beat", {out_data, out_sof, out_eol, out_eof}, {e.d, e.sof, e.eol, e.eof});
            want_rdy = e.pass_end;
          end
          n_beats++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_data, out_sof, out_eol, out_eof};
      end
    end
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_outputs", {out_valid, out_data, out_sof, out_eol, out_eof}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("release_in_ready", in_ready, 1);

    set_frame(0);
    push_frame();
    send_frame();
    drain();

    bp = 1'b1;
    set_frame(9);
    push_frame();
    send_frame();
    drain();
    bp = 1'b0;

    // Row 0 emits normally, then a partial row is discarded by in_sof.
    set_frame(0);
    push_row(0);
    send_row(0);
    send_px(frame_px[1][0], 1'b0);
    set_frame(5);
    push_frame();
    send_frame();
    drain();

    set_frame(20);
    push_row(0);
    send_row(0);
    base = n_beats;
    n = 0;
    while (n_beats < base + 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("beats_before_rst", n_beats, base + 3);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("abort_outputs", {out_valid, in_ready, out_data, out_sof, out_eol, out_eof}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);

    set_frame(30);
    push_frame();
    send_frame();
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
